gps_sample_packer: RTL and testbench
====================================

// Module: gps_sample_packer
// PURPOSE
//  Writer side of the GPS-to-MCU sample path, clocked in the GPS domain.
//  Samples the 4-bit I/Q front-end word on every GPS_CLK_4_092 edge and packs two samples per byte.
//  Buffers the bytes in a small FIFO and hands each one across to the MCU-clock SPI bridge.
//  The crossing uses a toggle req/ack handshake; overflow is detected and counted.
// PARAMETERS
//  FIFO_DEPTH   4    byte entries; power of 2, >=2
//  CNT_W        16   width of DROP_COUNT (saturating)
// PORTS
//  GPS_CLK_4_092  in   1      sample clock; all state on rising edge
//  RESET_N        in   1      reset, asynchronous, active-low
//  GPS_I0/I1/Q0/Q1 in  1 each front-end bits, synchronous to GPS_CLK_4_092
//  ENABLE         in   1      capture enable, async (MCU domain), 2-FF synchronized -> en_s
//  ACK_TOGGLE     in   1      reader ack, async (MCU domain), 2-FF synchronized -> ack_s
//  DATA_OUT       out  8      byte offered to reader; stable while a transfer is pending
//  REQ_TOGGLE     out  1      toggles once per new byte offered
//  OVERFLOW       out  1      sticky: >=1 byte dropped since last clear
//  DROP_COUNT     out  CNT_W  bytes dropped, saturates at all-ones
// BEHAVIOUR
//  Reset: DATA_OUT=0, REQ_TOGGLE=0, OVERFLOW=0, DROP_COUNT=0, FIFO empty, phase=0, sync FFs=0.
//  Nibble = {I1,I0,Q1,Q0}. Byte = {first nibble[7:4], second nibble[3:0]}.
//  Packing: en_s=1, phase=0 -> latch nibble to hi reg, phase<=1.
//    en_s=1, phase=1 -> push {hi,nibble}, phase<=0.
//  en_s=0: phase<=0, a held hi nibble is discarded, no pushes; FIFO keeps draining.
//  en_s rising (0->1 seen on synchronized value): OVERFLOW<=0, DROP_COUNT<=0.
//    The sample of that same cycle is the hi nibble.
//  Push: accepted if !full OR a pop occurs in the same cycle.
//    Otherwise the byte is dropped, OVERFLOW<=1, DROP_COUNT<=DROP_COUNT+1 (saturate).
//  Pending = (REQ_TOGGLE != ack_s). Pop when !pending && !empty.
//    On the pop edge: DATA_OUT<=head, REQ_TOGGLE<=~REQ_TOGGLE.
//  One byte in flight max; next pop no earlier than the cycle after ack_s matches REQ_TOGGLE.
//  Empty FIFO + push with no pending: byte reaches DATA_OUT on the next edge (no bypass).
//  Latency: hi sample at edge n, lo at n+1 -> FIFO at n+1 -> DATA_OUT/REQ_TOGGLE at n+2.
//  Push and pop on a full FIFO in one cycle: both happen, count unchanged, no drop.
//  Read/write pointers wrap modulo FIFO_DEPTH; count width log2(FIFO_DEPTH)+1.
//  Reset mid-transfer: everything returns to reset values.
//    Reader must also reset; a stale ACK toggle after reset is not tolerated.
//  Throughput: 2.046 MB/s in; reader round-trip must stay <2 GPS clocks on average or drops occur.
// STRUCTURE
//  gps_bridge_pkg: IQ bit positions in nibble, SAMPLE_W=4, BYTE_W=8, handshake polarity constants.
//  Sub-module: gps_byte_fifo (single-clock, parameterized depth, push/pop/full/empty/count).
//  ENABLE and ACK_TOGGLE each pass through the existing 2-FF synchronizer cell.
// TESTING
//  1 I/Q nibbles 0xA,0x5 with ENABLE=1 and an instant-ack reader model
//    -> DATA_OUT=0xA5, one REQ toggle, 2 cycles after the lo nibble.
//  2 Stream 0x1..0x8; reader acks every 8 cycles
//    -> bytes 0x12,0x34,0x56,0x78 in order, OVERFLOW=0.
//  3 Reader never acks, 14 nibbles sent -> FIFO holds 4 bytes + 1 in DATA_OUT.
//    -> Remaining 2 bytes dropped, OVERFLOW=1, DROP_COUNT=2. DATA_OUT unchanged.
//  4 FIFO full, ack arrives on the same cycle as a push -> push accepted, DROP_COUNT unchanged.
//  5 ENABLE drops after one nibble, then re-rises with 0x3,0xC
//    -> next byte 0x3C, stale nibble gone.
//    -> OVERFLOW/DROP_COUNT cleared on the re-enable.
//  6 Assert RESET_N low with a byte pending -> all outputs go to 0 at once.
//    -> After release, the first byte is the first full pair captured.

Source files
------------

// File: rtl/gps_bridge_pkg.sv
// Shared constants and types for the GPS-to-MCU sample bridge.
// Nibble bit positions, sample/byte widths and handshake idle level live here.
package gps_bridge_pkg;

    localparam int SAMPLE_W = 4;
    localparam int BYTE_W   = 8;

    localparam int IQ_Q0 = 0;
    localparam int IQ_Q1 = 1;
    localparam int IQ_I0 = 2;
    localparam int IQ_I1 = 3;

    localparam logic HS_IDLE = 1'b0;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } phase_e;

    function automatic logic [SAMPLE_W-1:0] pack_nibble(input logic i1, input logic i0,
                                                        input logic q1, input logic q0);
        logic [SAMPLE_W-1:0] n;
        n        = '0;
        n[IQ_I1] = i1;
        n[IQ_I0] = i0;
        n[IQ_Q1] = q1;
        n[IQ_Q0] = q0;
        return n;
    endfunction

endpackage

// File: rtl/gps_byte_fifo.sv
// Single-clock byte FIFO; caller only pushes when not full (or popping) and pops when not empty.
module gps_byte_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic         GPS_CLK_4_092,
    input  logic         RESET_N,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             count;

    assign rdata = mem[rd_ptr];
    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);

    // Depth is a power of two, so pointer wrap is the natural overflow of AW bits.
    always_ff @(posedge GPS_CLK_4_092 or negedge RESET_N) begin
        if (!RESET_N) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gps_sync_2ff.sv
// Two-flop synchronizer cell for single-bit signals entering the GPS clock domain.
module gps_sync_2ff (
    input  logic GPS_CLK_4_092,
    input  logic RESET_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge GPS_CLK_4_092 or negedge RESET_N) begin
        if (!RESET_N) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/gps_sample_packer.sv
// Packs I/Q nibbles into bytes, buffers them and offers each to the MCU side
// over a toggle req/ack handshake, counting bytes lost to overflow.
module gps_sample_packer
    import gps_bridge_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic              GPS_CLK_4_092,
    input  logic              RESET_N,
    input  logic              GPS_I0,
    input  logic              GPS_I1,
    input  logic              GPS_Q0,
    input  logic              GPS_Q1,
    input  logic              ENABLE,
    input  logic              ACK_TOGGLE,
    output logic [BYTE_W-1:0] DATA_OUT,
    output logic              REQ_TOGGLE,
    output logic              OVERFLOW,
    output logic [CNT_W-1:0]  DROP_COUNT
);

    logic                en_s;
    logic                ack_s;
    logic                en_d;
    logic                en_rise;
    logic [SAMPLE_W-1:0] nibble;
    logic [SAMPLE_W-1:0] hi_q;
    phase_e              phase_q;
    phase_e              phase_d;
    logic                hi_load;
    logic                push_try;
    logic                push_ok;
    logic                drop;
    logic                pending;
    logic                pop;
    logic                full;
    logic                empty;
    logic [BYTE_W-1:0]   head;

    gps_sync_2ff u_sync [1:0] (
        .GPS_CLK_4_092 (GPS_CLK_4_092),
        .RESET_N       (RESET_N),
        .d             ({ACK_TOGGLE, ENABLE}),
        .q             ({ack_s, en_s})
    );

    assign nibble  = pack_nibble(GPS_I1, GPS_I0, GPS_Q1, GPS_Q0);
    assign en_rise = en_s && !en_d;
    assign pending = (REQ_TOGGLE != ack_s);
    assign pop     = !pending && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push_ok = push_try && (!full || pop);
    assign drop    = push_try && !push_ok;

    always_comb begin
        phase_d  = phase_q;
        hi_load  = 1'b0;
        push_try = 1'b0;
        if (!en_s) begin
            phase_d = PH_HI;
        end else begin
            case (phase_q)
                PH_HI: begin
                    hi_load = 1'b1;
                    phase_d = PH_LO;
                end
                PH_LO: begin
                    push_try = 1'b1;
                    phase_d  = PH_HI;
                end
                default: phase_d = PH_HI;
            endcase
        end
    end

    always_ff @(posedge GPS_CLK_4_092 or negedge RESET_N) begin
        if (!RESET_N) begin
            phase_q <= PH_HI;
            en_d    <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            en_d    <= en_s;
            if (hi_load) begin
                hi_q <= nibble;
            end else if (!en_s) begin
                hi_q <= '0;
            end
        end
    end

    gps_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .GPS_CLK_4_092 (GPS_CLK_4_092),
        .RESET_N       (RESET_N),
        .push          (push_ok),
        .wdata         ({hi_q, nibble}),
        .pop           (pop),
        .rdata         (head),
        .full          (full),
        .empty         (empty)
    );

    always_ff @(posedge GPS_CLK_4_092 or negedge RESET_N) begin
        if (!RESET_N) begin
            DATA_OUT   <= '0;
            REQ_TOGGLE <= HS_IDLE;
        end else if (pop) begin
            DATA_OUT   <= head;
            REQ_TOGGLE <= ~REQ_TOGGLE;
        end
    end

    // Statistics restart on each capture session.
    always_ff @(posedge GPS_CLK_4_092 or negedge RESET_N) begin
        if (!RESET_N) begin
            OVERFLOW   <= 1'b0;
            DROP_COUNT <= '0;
        end else if (en_rise) begin
            OVERFLOW   <= 1'b0;
            DROP_COUNT <= '0;
        end else if (drop) begin
            OVERFLOW <= 1'b1;
            if (DROP_COUNT != '1) begin
                DROP_COUNT <= DROP_COUNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_gps_sample_packer.sv
// Bench for gps_sample_packer: stream driver, reader model with scoreboard, corner sequences.
`timescale 1ns/1ps
module tb_gps_sample_packer;

    logic        GPS_CLK_4_092 = 1'b0;
    logic        RESET_N;
    logic        GPS_I0, GPS_I1, GPS_Q0, GPS_Q1;
    logic        ENABLE;
    logic        ACK_TOGGLE;
    logic [7:0]  DATA_OUT;
    logic        REQ_TOGGLE;
    logic        OVERFLOW;
    logic [15:0] DROP_COUNT;

    always #5 GPS_CLK_4_092 = ~GPS_CLK_4_092;

    gps_sample_packer #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
        .GPS_CLK_4_092 (GPS_CLK_4_092),
        .RESET_N       (RESET_N),
        .GPS_I0        (GPS_I0),
        .GPS_I1        (GPS_I1),
        .GPS_Q0        (GPS_Q0),
        .GPS_Q1        (GPS_Q1),
        .ENABLE        (ENABLE),
        .ACK_TOGGLE    (ACK_TOGGLE),
        .DATA_OUT      (DATA_OUT),
        .REQ_TOGGLE    (REQ_TOGGLE),
        .OVERFLOW      (OVERFLOW),
        .DROP_COUNT    (DROP_COUNT)
    );

    typedef struct {
        logic [3:0] hi;
        logic [3:0] lo;
        logic [7:0] exp;
    } vec_t;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];
    logic [3:0] nibs[$];
    int         ack_en    = 0;
    int         ack_delay = 0;
    int         kick_req  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reader model: compares each newly offered byte, then acks after ack_delay cycles.
    initial begin : reader
        logic       last_req;
        int         timer;
        int         kick_seen;
        logic [7:0] eb;
        last_req   = 1'b0;
        timer      = -1;
        kick_seen  = 0;
        ACK_TOGGLE = 1'b0;
        forever begin
            @(negedge GPS_CLK_4_092);
            if (!RESET_N) begin
                last_req   = 1'b0;
                ACK_TOGGLE = 1'b0;
                timer      = -1;
                kick_seen  = kick_req;
            end else begin
                if (REQ_TOGGLE != last_req) begin
                    last_req = REQ_TOGGLE;
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", int'(DATA_OUT), -1);
                    end else begin
                        eb = exp_q.pop_front();
                        check("rx_byte", int'(DATA_OUT), int'(eb));
                    end
                end
                if (kick_req != kick_seen) begin
                    kick_seen  = kick_req;
                    ACK_TOGGLE = last_req;
                end
                if (ack_en != 0 && ACK_TOGGLE != last_req && timer < 0) timer = ack_delay;
                if (timer == 0) begin
                    ACK_TOGGLE = last_req;
                    timer      = -1;
                end else if (timer > 0) begin
                    timer--;
                end
            end
        end
    end

    // ENABLE leads capture by two cycles (synchronizer), so the window is shifted accordingly.
    task automatic run_stream(input int kick_at);
        int len;
        len = nibs.size();
        for (int c = 0; c < len + 2; c++) begin
            ENABLE = (c < len);
            if (c >= 2) {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = nibs[c-2];
            else        {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = 4'h0;
            if (c == kick_at) kick_req++;
            @(posedge GPS_CLK_4_092); #1;
        end
        ENABLE = 1'b0;
        nibs.delete();
    endtask

    task automatic wait_drain(input string name);
        int k;
        k = 0;
        while (k < 300 && !(exp_q.size() == 0 && REQ_TOGGLE == ACK_TOGGLE)) begin
            @(posedge GPS_CLK_4_092); #1;
            k++;
        end
        check(name, exp_q.size(), 0);
        repeat (4) begin @(posedge GPS_CLK_4_092); #1; end
    endtask

    initial begin : main
        vec_t tbl[4];
        logic [3:0] n;
        tbl[0] = '{4'h1, 4'h2, 8'h12};
        tbl[1] = '{4'h3, 4'h4, 8'h34};
        tbl[2] = '{4'h5, 4'h6, 8'h56};
        tbl[3] = '{4'h7, 4'h8, 8'h78};

        RESET_N = 1'b0;
        ENABLE  = 1'b0;
        {GPS_I1, GPS_I0, GPS_Q1, GPS_Q0} = 4'h0;
        repeat (3) @(posedge GPS_CLK_4_092);
        #1;
        check("rst_data", int'(DATA_OUT), 0);
        check("rst_req", int'(REQ_TOGGLE), 0);
        check("rst_ovf", int'(OVERFLOW), 0);
        check("rst_drop", int'(DROP_COUNT), 0);
        @(negedge GPS_CLK_4_092);
        RESET_N = 1'b1;
        @(posedge GPS_CLK_4_092); #1;

        // 1: single byte, instant ack, latency two edges after the lo nibble
        ack_en = 1; ack_delay = 0;
        exp_q.push_back(8'hA5);
        nibs = '{4'hA, 4'h5};
        run_stream(-1);
        check("t1_req_not_yet", int'(REQ_TOGGLE), 0);
        @(posedge GPS_CLK_4_092); #1;
        check("t1_req", int'(REQ_TOGGLE), 1);
        check("t1_data", int'(DATA_OUT), 8'hA5);
        wait_drain("t1_drain");
        check("t1_one_toggle", int'(REQ_TOGGLE), 1);

        // 2: table stream, slow reader
        ack_en = 1; ack_delay = 8;
        for (int i = 0; i < 4; i++) begin
            nibs.push_back(tbl[i].hi);
            nibs.push_back(tbl[i].lo);
            exp_q.push_back(tbl[i].exp);
        end
        run_stream(-1);
        wait_drain("t2_drain");
        check("t2_ovf", int'(OVERFLOW), 0);
        check("t2_drop", int'(DROP_COUNT), 0);

        // 3: reader stalls, 7 bytes offered, FIFO + DATA_OUT hold 5
        ack_en = 0;
        for (int i = 0; i < 14; i++) begin
            n = 4'((i * 3 + 1) & 15);
            nibs.push_back(n);
        end
        exp_q.push_back(8'h14); exp_q.push_back(8'h7A); exp_q.push_back(8'hD0);
        exp_q.push_back(8'h36); exp_q.push_back(8'h9C);
        run_stream(-1);
        check("t3_ovf", int'(OVERFLOW), 1);
        check("t3_drop", int'(DROP_COUNT), 2);
        check("t3_data_held", int'(DATA_OUT), 8'h14);

        // 4: full FIFO, ack lands on the push cycle -> accepted; next push drops
        exp_q.push_back(8'hB1);
        nibs = '{4'hB, 4'h1, 4'h2, 4'h3};
        run_stream(1);
        check("t4_drop", int'(DROP_COUNT), 1);
        check("t4_ovf", int'(OVERFLOW), 1);
        ack_en = 1; ack_delay = 1;
        wait_drain("t4_drain");

        // 5: odd stream leaves a stale hi nibble; re-enable clears stats
        ack_en = 0;
        for (int i = 0; i < 13; i++) begin
            n = 4'((i * 5 + 2) & 15);
            nibs.push_back(n);
        end
        exp_q.push_back(8'h27); exp_q.push_back(8'hC1); exp_q.push_back(8'h6B);
        exp_q.push_back(8'h05); exp_q.push_back(8'hAF);
        run_stream(-1);
        check("t5_drop", int'(DROP_COUNT), 1);
        ack_en = 1; ack_delay = 1;
        wait_drain("t5_drain");
        check("t5_ovf_sticky", int'(OVERFLOW), 1);
        check("t5_drop_sticky", int'(DROP_COUNT), 1);
        exp_q.push_back(8'h3C);
        nibs = '{4'h3, 4'hC};
        run_stream(-1);
        check("t5_ovf_clr", int'(OVERFLOW), 0);
        check("t5_drop_clr", int'(DROP_COUNT), 0);
        wait_drain("t5_drain2");

        // 6: reset with a byte pending and drops counted
        ack_en = 0;
        for (int i = 0; i < 14; i++) begin
            n = 4'((i * 7 + 3) & 15);
            nibs.push_back(n);
        end
        exp_q.push_back(8'h3A); exp_q.push_back(8'h18); exp_q.push_back(8'hF6);
        exp_q.push_back(8'hD4); exp_q.push_back(8'hB2);
        run_stream(-1);
        check("t6_drop_pre", int'(DROP_COUNT), 2);
        #2;
        RESET_N = 1'b0;
        #1;
        check("t6_rst_data", int'(DATA_OUT), 0);
        check("t6_rst_req", int'(REQ_TOGGLE), 0);
        check("t6_rst_ovf", int'(OVERFLOW), 0);
        check("t6_rst_drop", int'(DROP_COUNT), 0);
        exp_q.delete();
        repeat (2) @(negedge GPS_CLK_4_092);
        RESET_N = 1'b1;
        @(posedge GPS_CLK_4_092); #1;
        ack_en = 1; ack_delay = 0;
        exp_q.push_back(8'hE1); exp_q.push_back(8'h24);
        nibs = '{4'hE, 4'h1, 4'h2, 4'h4};
        run_stream(-1);
        wait_drain("t6_drain");
        check("t6_ovf_after", int'(OVERFLOW), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
